// File: rtl/alu_mc_framer_pkg.sv
// Shared definitions for the multi-channel ALU result framer.
// Holds the FSM encoding and a width helper.
package alu_mc_framer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/alu_mc_fifo.sv
// Single-clock show-ahead FIFO, one per framer input channel.
// Pushes on full and pops on empty are ignored.
module alu_mc_fifo
    import alu_mc_framer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc_framer.sv
// Multi-channel ALU result framer: per-channel FIFOs, round-robin
// arbitration on whole buffered frames, SOF/EOF/channel tagged egress.
module alu_mc_framer
    import alu_mc_framer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 5,
    localparam int CH_W      = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
    localparam int CW        = clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LEN_W-1:0]         frame_len,
    input  logic                     frame_len_val,
    output logic                     len_err,
    input  logic [NUM_CH-1:0]        in_val,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_bp,
    output logic [NUM_CH-1:0]        ovf,
    output logic                     frame,
    output logic [DATA_W-1:0]        frame_data,
    output logic                     frame_sof,
    output logic                     frame_eof,
    output logic [CH_W-1:0]          frame_ch,
    input  logic                     out_bp
);

    logic [CW-1:0]     cnt  [NUM_CH];
    logic [DATA_W-1:0] head [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] elig;
    logic [0:0]        state;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W:0]    beat_cnt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt;
    logic              any_elig;
    logic              ld_beat;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        alu_mc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (in_val[c]),
            .push_data (in_data[c*DATA_W +: DATA_W]),
            .pop       (pop[c]),
            .pop_data  (head[c]),
            .count     (cnt[c]),
            .full      (in_bp[c]),
            .empty     (empty[c])
        );
        assign elig[c] = int'(cnt[c]) >= int'(len_reg) + 1;
        assign pop[c]  = ld_beat && (frame_ch == CH_W'(c));
    end

    // First eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        gnt      = '0;
        any_elig = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!any_elig && elig[c] &&
                    ((int'(rr_ptr) + i) % NUM_CH) == c) begin
                    any_elig = 1'b1;
                    gnt      = CH_W'(c);
                end
            end
        end
    end

    assign ld_beat = (state == ST_SEND) && (!frame || !out_bp) &&
                     (beat_cnt <= {1'b0, cur_len});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len_reg    <= '0;
            cur_len    <= '0;
            beat_cnt   <= '0;
            rr_ptr     <= '0;
            frame_ch   <= '0;
            frame      <= 1'b0;
            frame_data <= '0;
            frame_sof  <= 1'b0;
            frame_eof  <= 1'b0;
            len_err    <= 1'b0;
            ovf        <= '0;
        end else begin
            len_err <= 1'b0;
            if (frame_len_val) begin
                if (int'(frame_len) < FIFO_DEPTH) len_reg <= frame_len;
                else                              len_err <= 1'b1;
            end
            ovf <= ovf | (in_val & in_bp);
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        frame_ch <= gnt;
                        cur_len  <= len_reg;
                        beat_cnt <= '0;
                        state    <= ST_SEND;
                    end
                end
                default: begin
                    if (ld_beat) begin
                        frame      <= 1'b1;
                        frame_data <= head[frame_ch];
                        frame_sof  <= (beat_cnt == '0);
                        frame_eof  <= (beat_cnt == {1'b0, cur_len});
                        beat_cnt   <= beat_cnt + 1'b1;
                    end else if (frame && !out_bp) begin
                        frame     <= 1'b0;
                        frame_sof <= 1'b0;
                        frame_eof <= 1'b0;
                        if (frame_eof) begin
                            state  <= ST_IDLE;
                            rr_ptr <= (frame_ch == CH_W'(NUM_CH - 1)) ?
                                      '0 : frame_ch + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_framer.sv
// Directed bench for alu_mc_framer with default parameters
// (2 channels, 16-deep FIFOs, 32-bit data).
module tb_alu_mc_framer;

    logic        clk;
    logic        rst_n;
    logic [4:0]  frame_len;
    logic        frame_len_val;
    logic        len_err;
    logic [1:0]  in_val;
    logic [63:0] in_data;
    logic [1:0]  in_bp;
    logic [1:0]  ovf;
    logic        frame;
    logic [31:0] frame_data;
    logic        frame_sof;
    logic        frame_eof;
    logic [0:0]  frame_ch;
    logic        out_bp;

    int vectors;
    int errors;

    alu_mc_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_len     (frame_len),
        .frame_len_val (frame_len_val),
        .len_err       (len_err),
        .in_val        (in_val),
        .in_data       (in_data),
        .in_bp         (in_bp),
        .ovf           (ovf),
        .frame         (frame),
        .frame_data    (frame_data),
        .frame_sof     (frame_sof),
        .frame_eof     (frame_eof),
        .frame_ch      (frame_ch),
        .out_bp        (out_bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        in_val        = '0;
        in_data       = '0;
        frame_len     = '0;
        frame_len_val = 1'b0;
        out_bp        = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_len(input logic [4:0] v);
        frame_len     = v;
        frame_len_val = 1'b1;
        tick();
        frame_len_val = 1'b0;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        in_val              = '0;
        in_val[ch]          = 1'b1;
        in_data             = '0;
        in_data[ch*32 +: 32] = d;
        tick();
        in_val = '0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (frame === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_val = '0; in_data = '0; out_bp = 1'b0;
        frame_len = '0; frame_len_val = 1'b0;
        #3;
        vectors++;
        if (frame !== 1'b0 || frame_sof !== 1'b0 || frame_eof !== 1'b0 ||
            in_bp !== 2'b00 || ovf !== 2'b00 || len_err !== 1'b0 ||
            frame_data !== 32'h0 || frame_ch !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got f=%b s=%b e=%b bp=%b ovf=%b le=%b d=%h ch=%b want all 0",
                     frame, frame_sof, frame_eof, in_bp, ovf, len_err, frame_data, frame_ch);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        do_reset();
        set_len(5'd3);
        vectors++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_len_ok: got len_err=%b want 0", len_err);
        end
        push(0, 32'h11); push(0, 32'h22); push(0, 32'h33); push(0, 32'h44);
        tick();
        vectors++;
        if (frame !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1: got frame=%b want 0", frame);
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0 || 1) tick();
            exp = 32'h11 * (k + 1);
            vectors++;
            if (frame !== 1'b1 || frame_data !== exp || frame_sof !== (k == 0) ||
                frame_eof !== (k == 3) || frame_ch !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: got f=%b d=%h s=%b e=%b ch=%b want f=1 d=%h s=%b e=%b ch=0",
                         k, frame, frame_data, frame_sof, frame_eof, frame_ch, exp, k == 0, k == 3);
            end
        end
        tick();
        vectors++;
        if (frame !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got frame=%b want 0", frame);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] bd [16];
        logic        bch [16];
        logic        bs [16];
        logic        be [16];
        int nb, idle_run, min_gap, f;
        logic [31:0] exp;
        do_reset();
        set_len(5'd1);
        nb = 0; idle_run = 0; min_gap = 99;
        for (int cyc = 0; cyc < 120 && nb < 16; cyc++) begin
            if (cyc < 8) begin
                in_val  = 2'b11;
                in_data = {32'hB0 + 32'(cyc), 32'hA0 + 32'(cyc)};
            end else begin
                in_val  = 2'b00;
                in_data = '0;
            end
            tick();
            if (frame === 1'b1) begin
                if (frame_sof === 1'b1 && nb > 0 && idle_run < min_gap)
                    min_gap = idle_run;
                bd[nb] = frame_data; bch[nb] = frame_ch;
                bs[nb] = frame_sof;  be[nb]  = frame_eof;
                nb++;
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
        in_val = '0;
        vectors++;
        if (nb != 16) begin
            errors++;
            $display("FAIL rr_beat_count: got %0d want 16", nb);
        end
        for (int k = 0; k < nb; k++) begin
            f   = k / 2;
            exp = ((f % 2) ? 32'hB0 : 32'hA0) + 32'((f / 2) * 2 + k % 2);
            vectors++;
            if (bd[k] !== exp || bch[k] !== 1'(f % 2) ||
                bs[k] !== (k % 2 == 0) || be[k] !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_beat%0d: got d=%h ch=%b s=%b e=%b want d=%h ch=%0d s=%b e=%b",
                         k, bd[k], bch[k], bs[k], be[k], exp, f % 2, k % 2 == 0, k % 2 == 1);
            end
        end
        vectors++;
        if (min_gap < 1) begin
            errors++;
            $display("FAIL rr_gap: got min gap %0d want >=1", min_gap);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        set_len(5'd3);
        push(0, 32'hC0); push(0, 32'hC1); push(0, 32'hC2); push(0, 32'hC3);
        wait_frame(ok);
        vectors++;
        if (!ok || frame_data !== 32'hC0 || frame_sof !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got ok=%b d=%h s=%b want ok=1 d=c0 s=1", ok, frame_data, frame_sof);
        end
        tick();
        vectors++;
        if (frame !== 1'b1 || frame_data !== 32'hC1) begin
            errors++;
            $display("FAIL bp_second: got f=%b d=%h want f=1 d=c1", frame, frame_data);
        end
        out_bp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (frame !== 1'b1 || frame_data !== 32'hC1 || frame_eof !== 1'b0 || frame_sof !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got f=%b d=%h s=%b e=%b want f=1 d=c1 s=0 e=0",
                         i, frame, frame_data, frame_sof, frame_eof);
            end
        end
        out_bp = 1'b0;
        tick();
        vectors++;
        if (frame !== 1'b1 || frame_data !== 32'hC2 || frame_eof !== 1'b0) begin
            errors++;
            $display("FAIL bp_third: got f=%b d=%h e=%b want f=1 d=c2 e=0", frame, frame_data, frame_eof);
        end
        tick();
        vectors++;
        if (frame !== 1'b1 || frame_data !== 32'hC3 || frame_eof !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: got f=%b d=%h e=%b want f=1 d=c3 e=1", frame, frame_data, frame_eof);
        end
        tick();
        vectors++;
        if (frame !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: got frame=%b want 0", frame);
        end
    endtask

    task automatic test_overflow();
        int nb, bad, seen;
        do_reset();
        set_len(5'd15);
        out_bp = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(1, 32'hD0 + 32'(i));
            if (i == 14) begin
                vectors++;
                if (in_bp[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_bp15: got in_bp=%b want 0 after 15 pushes", in_bp);
                end
            end
        end
        vectors++;
        if (in_bp !== 2'b10 || ovf !== 2'b00) begin
            errors++;
            $display("FAIL ovf_full: got in_bp=%b ovf=%b want in_bp=10 ovf=00", in_bp, ovf);
        end
        push(1, 32'hDEAD);
        vectors++;
        if (ovf !== 2'b10) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b want 10", ovf);
        end
        repeat (3) tick();
        out_bp = 1'b0;
        nb = 0; bad = 0;
        for (int cyc = 0; cyc < 60 && nb < 16; cyc++) begin
            if (frame === 1'b1) begin
                if (frame_data !== 32'hD0 + 32'(nb) || frame_ch !== 1'b1 ||
                    frame_eof !== (nb == 15) || frame_sof !== (nb == 0)) begin
                    bad++;
                    $display("FAIL ovf_beat%0d: got d=%h ch=%b s=%b e=%b want d=%h ch=1",
                             nb, frame_data, frame_ch, frame_sof, frame_eof, 32'hD0 + 32'(nb));
                end
                nb++;
            end
            tick();
        end
        vectors++;
        errors += bad;
        if (nb != 16) begin
            errors++;
            $display("FAIL ovf_drain: got %0d beats want 16", nb);
        end
        set_len(5'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (frame === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || ovf !== 2'b10) begin
            errors++;
            $display("FAIL ovf_dropped: got %0d extra beats ovf=%b want 0 beats ovf=10", seen, ovf);
        end
    endtask

    task automatic test_len_rules();
        bit ok;
        do_reset();
        set_len(5'd3);
        frame_len     = 5'd16;
        frame_len_val = 1'b1;
        tick();
        frame_len_val = 1'b0;
        vectors++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_err_pulse: got %b want 1", len_err);
        end
        tick();
        vectors++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_err_clear: got %b want 0", len_err);
        end
        for (int i = 0; i < 5; i++) push(0, 32'hE0 + 32'(i));
        wait_frame(ok);
        vectors++;
        if (!ok || frame_data !== 32'hE0 || frame_sof !== 1'b1 || frame_eof !== 1'b0) begin
            errors++;
            $display("FAIL len_first: got ok=%b d=%h s=%b e=%b want d=e0 s=1 e=0",
                     ok, frame_data, frame_sof, frame_eof);
        end
        frame_len     = 5'd0;
        frame_len_val = 1'b1;
        tick();
        frame_len_val = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (k > 1) tick();
            vectors++;
            if (frame !== 1'b1 || frame_data !== 32'hE0 + 32'(k) || frame_eof !== (k == 3)) begin
                errors++;
                $display("FAIL len_keep%0d: got f=%b d=%h e=%b want f=1 d=%h e=%b",
                         k, frame, frame_data, frame_eof, 32'hE0 + 32'(k), k == 3);
            end
        end
        tick();
        wait_frame(ok);
        vectors++;
        if (!ok || frame_data !== 32'hE4 || frame_sof !== 1'b1 || frame_eof !== 1'b1) begin
            errors++;
            $display("FAIL len_one_beat: got ok=%b d=%h s=%b e=%b want d=e4 s=1 e=1",
                     ok, frame_data, frame_sof, frame_eof);
        end
        tick();
        vectors++;
        if (frame !== 1'b0) begin
            errors++;
            $display("FAIL len_end: got frame=%b want 0", frame);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        set_len(5'd3);
        out_bp = 1'b1;
        for (int i = 0; i < 30 && in_bp[1] !== 1'b1; i++) push(1, 32'hF0 + 32'(i));
        push(1, 32'hFFFF);
        vectors++;
        if (in_bp[1] !== 1'b1 || ovf !== 2'b10) begin
            errors++;
            $display("FAIL rst_setup: got in_bp=%b ovf=%b want in_bp[1]=1 ovf=10", in_bp, ovf);
        end
        out_bp = 1'b0;
        tick();
        vectors++;
        if (frame !== 1'b1 || frame_sof !== 1'b0 || frame_data !== 32'hF1) begin
            errors++;
            $display("FAIL rst_beat2: got f=%b s=%b d=%h want f=1 s=0 d=f1", frame, frame_sof, frame_data);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (frame !== 1'b0 || frame_eof !== 1'b0 || in_bp !== 2'b00 || ovf !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got f=%b e=%b in_bp=%b ovf=%b want all 0",
                     frame, frame_eof, in_bp, ovf);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (frame === 1'b1 || in_bp !== 2'b00) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_empty: got %0d cycles with activity want 0", seen);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_len_rules();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
